load_store_unit: RTL
====================

# load_store_unit

Core-side initiator for the single-cycle RV32I data memory. It accepts one load/store request at a time from the execute stage and drives the memory's word-wide `address`/`read`/`write` port. The memory has no byte enables, so SB/SH are performed as aligned read-modify-write. The unit also produces byte/halfword extraction with sign or zero extension for loads, and flags misaligned or illegal accesses.

## Interface
- `AW`, 32, memory address width
- `DW`, 32, data width; fixed at 32
- `clk` input 1 — sole clock, rising edge
- `rst_n` input 1 — asynchronous, active-low reset
- `req_valid` input 1 — request present
- `req_ready` output 1 — unit can accept; high only in IDLE
- `req_we` input 1 — 1 = store, 0 = load
- `req_funct3` input 3 — RV32I funct3: LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2
- `req_addr` input AW — byte address
- `req_wdata` input DW — store data, right-aligned (rs2)
- `resp_valid` output 1 — one-cycle completion pulse
- `resp_err` output 1 — misaligned or illegal funct3; valid with `resp_valid`
- `resp_rdata` output DW — extended load result; 0 for stores and errors
- `mem_address` output AW — always word-aligned (`addr & ~3`)
- `mem_read` output 1 — memory read strobe
- `mem_write` output 1 — memory write strobe
- `mem_wdata` output DW — full-word write data
- `mem_rdata` input DW — memory read data, valid the cycle after `mem_read`

## Operation
- Little-endian: byte k of the word equals `mem_rdata[8k+7:8k]` and addresses `mem_address + k`.
- Error cases, checked at accept:
  - halfword with `addr[0]=1`
  - word with `addr[1:0]≠0`
  - load funct3 ∈ {3,6,7}
  - store funct3 ≥ 3
- An error request makes no memory access.
- FSM states: IDLE, RD, LCAP, MERGE, WR, RESP.
  - IDLE: on `req_valid`, latch the request. Error → RESP with err. Load → RD. SW → WR with `mem_wdata = req_wdata`. SB/SH → RD.
  - RD: `mem_read=1` → load: LCAP; store: MERGE.
  - LCAP: extract byte/half at `addr[1:0]`, sign-extend (LB/LH) or zero-extend (LBU/LHU/LW) into the response register → RESP.
  - MERGE: replace the target byte lanes of `mem_rdata` with `req_wdata[7:0]` or `req_wdata[15:0]` into the write register → WR.
  - WR: `mem_write=1` → RESP.
  - RESP: `resp_valid=1` → IDLE.
- All `mem_*` and `resp_*` outputs are registered.
- `req_*` inputs are ignored outside IDLE; no queueing.

## Timing
- C0 is the accept cycle (`req_valid & req_ready`).
- Latency:
  - Load: `mem_read` in C1, `resp_valid` in C3.
  - SW: `mem_write` in C1, `resp_valid` in C2.
  - SB/SH: `mem_read` in C1, `mem_write` in C3, `resp_valid` in C4.
  - Error: `resp_valid` + `resp_err` in C1.
- `req_ready` is high in IDLE only, so back-to-back throughput is one request per latency+1 cycles. The next accept may occur in the cycle after RESP.
- `mem_read` and `mem_write` are never high in the same cycle. Each is a single-cycle pulse.
- `mem_address` holds its value from C1 until the next accept.
- Reset values:
  - all outputs 0 except `req_ready`, which is 1 (state = IDLE);
  - all internal registers 0.
- Reset mid-operation: outputs go to reset values asynchronously. `mem_write` drops immediately, so a pending RMW is aborted with no write issued if reset lands before WR. No response is produced for the aborted request.

## Structure
- Shared package `rv32i_pkg` holds:
  - funct3 encodings (LB…LHU, SB/SH/SW);
  - LSU state encoding localparams;
  - the byte-lane constants.
- Sub-module `lsu_align` (combinational):
  - load path: `addr[1:0]`, funct3, `mem_rdata` → extended result;
  - store path: `addr[1:0]`, funct3, old word, `req_wdata` → merged word.
- The FSM and registers stay in `load_store_unit`.

## Test plan
- Preload word 0x8899AABB at 0x10. LB @0x13 → `resp_rdata` = 0xFFFFFF88 in C3. LBU @0x13 → 0x00000088. No `mem_write` for either.
- Same preload. LH @0x12 → 0xFFFF8899. LHU @0x10 → 0x0000AABB. LW @0x10 → 0x8899AABB. `mem_address` = 0x10 throughout.
- Same preload. SB `wdata`=0x5A @0x11 → `mem_read` C1, `mem_write` C3 with `mem_wdata` = 0x88995ABB, `resp_valid` C4. Follow-up LW @0x10 → 0x88995ABB.
- SW 0x12345678 @0x20 → `mem_write` C1, `resp_valid` C2. Then SH 0xBEEF @0x22 → word 0xBEEF5678.
- Error cases, each `resp_err=1` in C1 with zero `mem_read`/`mem_write` pulses:
  - LW @0x12
  - SH @0x21
  - load funct3=3
- Assert `rst_n=0` during MERGE of an SB → all outputs 0 immediately, no `mem_write`, target word unchanged. After release, `req_ready=1` and a new LW completes normally.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store encodings, LSU state encoding and byte-lane constants.
package rv32i_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD    = 3'd1;
    localparam logic [2:0] ST_LCAP  = 3'd2;
    localparam logic [2:0] ST_MERGE = 3'd3;
    localparam logic [2:0] ST_WR    = 3'd4;
    localparam logic [2:0] ST_RESP  = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        RD    = ST_RD,
        LCAP  = ST_LCAP,
        MERGE = ST_MERGE,
        WR    = ST_WR,
        RESP  = ST_RESP
    } lsu_state_e;

    localparam int BYTE_W = 8;
    localparam int LANES  = 4;

    // Illegal funct3 for the direction, or an access not aligned to its size.
    function automatic logic req_illegal(input logic we, input logic [2:0] f3,
                                         input logic [1:0] addr_lo);
        logic bad_f3;
        logic misaligned;
        if (we)
            bad_f3 = (f3 > F3_SW);
        else
            bad_f3 = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        misaligned = ((f3[1:0] == F3_LH[1:0]) && addr_lo[0]) ||
                     ((f3[1:0] == F3_LW[1:0]) && (addr_lo != 2'b00));
        return bad_f3 | misaligned;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: load extraction/extension and store byte-lane merge.
module lsu_align
    import rv32i_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_byte = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign ld_half = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

    always_comb begin
        load_data_o = rdata_i;
        case (funct3_i[1:0])
            F3_LB[1:0]: load_data_o = funct3_i[2] ? {24'b0, ld_byte}
                                                  : {{24{ld_byte[7]}}, ld_byte};
            F3_LH[1:0]: load_data_o = funct3_i[2] ? {16'b0, ld_half}
                                                  : {{16{ld_half[15]}}, ld_half};
            default:    load_data_o = rdata_i;
        endcase
    end

    // Each lane takes new data only when the store covers it; otherwise the old byte survives.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        logic byte_hit;
        logic half_hit;
        logic word_hit;

        assign byte_hit = (funct3_i[1:0] == F3_SB[1:0]) && (addr_lo_i == LANE);
        assign half_hit = (funct3_i[1:0] == F3_SH[1:0]) && (addr_lo_i[1] == LANE[1]);
        assign word_hit = (funct3_i[1:0] == F3_SW[1:0]);

        assign store_data_o[BYTE_W*gi +: BYTE_W] =
            word_hit ? wdata_i[BYTE_W*gi +: BYTE_W] :
            byte_hit ? wdata_i[7:0] :
            half_hit ? (LANE[0] ? wdata_i[15:8] : wdata_i[7:0]) :
                       rdata_i[BYTE_W*gi +: BYTE_W];
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32I load/store initiator for a word-wide memory without byte
// enables; sub-word stores are done as aligned read-modify-write.
module load_store_unit
    import rv32i_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    output logic          resp_err,
    output logic [DW-1:0] resp_rdata,
    output logic [AW-1:0] mem_address,
    output logic          mem_read,
    output logic          mem_write,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    lsu_state_e    state_q, state_d;
    logic [1:0]    addr_lo_q;
    logic [2:0]    funct3_q;
    logic          we_q;
    logic [DW-1:0] wdata_q;
    logic          resp_valid_q, resp_err_q;
    logic [DW-1:0] resp_rdata_q;
    logic [AW-1:0] mem_address_q;
    logic          mem_read_q, mem_write_q;
    logic [DW-1:0] mem_wdata_q;

    logic          accept;
    logic          illegal;
    logic [DW-1:0] load_data;
    logic [DW-1:0] store_data;

    assign accept  = req_valid && (state_q == IDLE);
    assign illegal = req_illegal(req_we, req_funct3, req_addr[1:0]);

    lsu_align u_align (
        .addr_lo_i    (addr_lo_q),
        .funct3_i     (funct3_q),
        .rdata_i      (mem_rdata),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .store_data_o (store_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (illegal)
                        state_d = RESP;
                    else if (req_we && (req_funct3 == F3_SW))
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            RD:      state_d = we_q ? MERGE : LCAP;
            LCAP:    state_d = RESP;
            MERGE:   state_d = WR;
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are registered from the next state so each lands in the cycle it names.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            addr_lo_q     <= '0;
            funct3_q      <= '0;
            we_q          <= 1'b0;
            wdata_q       <= '0;
            resp_valid_q  <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_rdata_q  <= '0;
            mem_address_q <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_wdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            mem_read_q   <= (state_d == RD);
            mem_write_q  <= (state_d == WR);
            resp_valid_q <= (state_d == RESP);

            if (accept) begin
                addr_lo_q     <= req_addr[1:0];
                funct3_q      <= req_funct3;
                we_q          <= req_we;
                wdata_q       <= req_wdata;
                mem_address_q <= {req_addr[AW-1:2], 2'b00};
                resp_err_q    <= illegal;
                resp_rdata_q  <= '0;
                if (req_we && (req_funct3 == F3_SW) && !illegal)
                    mem_wdata_q <= req_wdata;
            end

            if (state_q == LCAP)
                resp_rdata_q <= load_data;
            if (state_q == MERGE)
                mem_wdata_q <= store_data;
            if (state_q == RESP) begin
                resp_err_q   <= 1'b0;
                resp_rdata_q <= '0;
            end
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign resp_valid  = resp_valid_q;
    assign resp_err    = resp_err_q;
    assign resp_rdata  = resp_rdata_q;
    assign mem_address = mem_address_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_wdata   = mem_wdata_q;

endmodule
